// File: rtl/zycap_axis_mux.sv
// Four-to-one AXI-Stream mux feeding the ICAP writer. Selection changes only on packet
// boundaries; drop mode swallows the selected packet and counts the discarded beats.
module zycap_axis_mux #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  axis_aclk,
    input  logic                  axis_aresetn,
    input  logic                  mux_en,
    input  logic                  mux_drop,
    input  logic [1:0]            mux_sel,
    input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
    input  logic                  s0_axis_tvalid,
    input  logic                  s0_axis_tlast,
    output logic                  s0_axis_tready,
    input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
    input  logic                  s1_axis_tvalid,
    input  logic                  s1_axis_tlast,
    output logic                  s1_axis_tready,
    input  logic [DATA_WIDTH-1:0] s2_axis_tdata,
    input  logic                  s2_axis_tvalid,
    input  logic                  s2_axis_tlast,
    output logic                  s2_axis_tready,
    input  logic [DATA_WIDTH-1:0] s3_axis_tdata,
    input  logic                  s3_axis_tvalid,
    input  logic                  s3_axis_tlast,
    output logic                  s3_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  mux_busy,
    output logic [15:0]           drop_count
);

    typedef enum logic [1:0] {
        StIdle,
        StPass,
        StDrop
    } state_e;

    state_e                state;
    logic [1:0]            sel_q;

    logic [DATA_WIDTH-1:0] src_data [4];
    logic [3:0]            src_valid;
    logic [3:0]            src_last;
    logic [3:0]            src_ready;

    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_valid;
    logic                  sel_last;
    logic                  src_hs;
    logic                  out_free;

    assign src_data[0] = s0_axis_tdata;
    assign src_data[1] = s1_axis_tdata;
    assign src_data[2] = s2_axis_tdata;
    assign src_data[3] = s3_axis_tdata;

    assign src_valid = {s3_axis_tvalid, s2_axis_tvalid, s1_axis_tvalid, s0_axis_tvalid};
    assign src_last  = {s3_axis_tlast, s2_axis_tlast, s1_axis_tlast, s0_axis_tlast};

    assign s0_axis_tready = src_ready[0];
    assign s1_axis_tready = src_ready[1];
    assign s2_axis_tready = src_ready[2];
    assign s3_axis_tready = src_ready[3];

    assign sel_data  = src_data[sel_q];
    assign sel_valid = src_valid[sel_q];
    assign sel_last  = src_last[sel_q];

    // The output register can take a new beat if it is empty or draining this cycle.
    assign out_free = ~m_axis_tvalid | m_axis_tready;
    assign src_hs   = sel_valid & src_ready[sel_q];

    always_comb begin
        src_ready = '0;
        unique case (state)
            StPass:  src_ready[sel_q] = out_free;
            StDrop:  src_ready[sel_q] = 1'b1;
            default: ;
        endcase
    end

    assign mux_busy = (state != StIdle) | m_axis_tvalid;

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state         <= StIdle;
            sel_q         <= 2'd0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            drop_count    <= 16'd0;
        end else begin
            // Drain applies in every state; a fresh beat loaded below takes priority.
            if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            unique case (state)
                StIdle: begin
                    if (mux_en) begin
                        sel_q <= mux_sel;
                        state <= mux_drop ? StDrop : StPass;
                    end
                end
                StPass: begin
                    if (src_hs) begin
                        m_axis_tdata  <= sel_data;
                        m_axis_tlast  <= sel_last;
                        m_axis_tvalid <= 1'b1;
                        if (sel_last) begin
                            state <= StIdle;
                        end
                    end
                end
                StDrop: begin
                    if (src_hs) begin
                        if (drop_count != 16'hFFFF) begin
                            drop_count <= drop_count + 16'd1;
                        end
                        if (sel_last) begin
                            state <= StIdle;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/zycap_axis_mux.md
Name: zycap_axis_mux

Overview:
- Downstream consumer of the zycap control register outputs (mux_en, mux_drop, mux_sel).
- Routes one of four AXI-Stream bitstream sources to a single master stream that feeds the ICAP writer.
- Selection is taken only on packet boundaries, so a partial bitstream is never split or interleaved.
- Drop mode consumes the selected source's packet and discards it, which flushes a stale or unwanted bitstream.

Parameters:
- DATA_WIDTH, 32: tdata width of all streams; must be a multiple of 8.

Ports:
- axis_aclk  in  1  stream clock
- axis_aresetn  in  1  asynchronous active-low reset
- mux_en  in  1  enable; from control reg0[0]
- mux_drop  in  1  drop mode; from control reg0[1]
- mux_sel  in  2  source select; from control reg0[3:2]
- s0_axis_tdata .. s3_axis_tdata  in  DATA_WIDTH  source data, one bus per source
- s0_axis_tvalid .. s3_axis_tvalid  in  1  source valid
- s0_axis_tlast .. s3_axis_tlast  in  1  source end of packet
- s0_axis_tready .. s3_axis_tready  out  1  source ready
- m_axis_tdata  out  DATA_WIDTH  output data (registered)
- m_axis_tvalid  out  1  output valid
- m_axis_tlast  out  1  output end of packet
- m_axis_tready  in  1  ICAP-side ready
- mux_busy  out  1  high when the FSM is not IDLE, or when m_axis_tvalid is high
- drop_count  out  16  beats discarded since reset; saturates at 16'hFFFF

Behaviour:
- Reset is asynchronous, active-low:
  - state=IDLE; sel_q=0.
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
  - All sN_axis_tready=0; drop_count=0; mux_busy=0.
- Reset mid-packet abandons the transfer immediately; an in-flight output beat is lost. No recovery of a partial packet.
- State IDLE:
  - All sN_axis_tready=0.
  - If mux_en=1, set sel_q<=mux_sel. Go to DROP if mux_drop=1, otherwise go to PASS.
  - If mux_en=0, stay in IDLE.
- Control inputs are sampled only in IDLE. Changes to mux_en, mux_drop or mux_sel during PASS or DROP are ignored until the packet ends.
- State PASS:
  - Only source sel_q is served; every other sN_axis_tready=0.
  - s[sel_q]_tready = ~m_axis_tvalid | m_axis_tready.
  - On a source handshake (valid and ready both high): m_axis_tdata/tlast <= source tdata/tlast, and m_axis_tvalid<=1.
  - If there is an output handshake and no source handshake in the same cycle, m_axis_tvalid<=0.
  - Latency is exactly 1 cycle from source handshake to m_axis_tvalid. With m_axis_tready held high, throughput is one beat per cycle.
  - The accepted beat with tlast=1 causes state<=IDLE. The final beat stays in the output register and drains from IDLE or from the next state; the output register obeys the same rules in every state.
- State DROP:
  - s[sel_q]_tready=1; other sources are held at ready=0.
  - Each handshake increments drop_count, saturating at 16'hFFFF.
  - Nothing is written to the output register.
  - A handshake beat with tlast=1 causes state<=IDLE.
- Re-entry from IDLE:
  - The earliest new selection is the cycle after the tlast handshake.
  - If mux_en is still 1, the FSM re-enters PASS or DROP immediately using the current mux_sel and mux_drop.
  - This allows back-to-back packets with a 1-cycle bubble.
- A source with tvalid=0 in PASS or DROP causes the FSM to wait indefinitely. There is no timeout.
- A pending output beat (m_axis_tvalid=1, m_axis_tready=0) in PASS stalls the source: tready=0 until the beat is accepted.

Test Plan:
- Reset then sel=2, drop=0, en=1. s2 sends 4 beats 0xA0..0xA3 with tlast on 0xA3, m_tready=1 -> m_axis emits 0xA0..0xA3, each 1 cycle after its input handshake; tlast on 0xA3; s0, s1, s3 tready stay 0 throughout.
- Backpressure: m_tready toggled 1/0 every cycle during the 4-beat s1 packet -> no beat lost or duplicated; m_axis_tdata is held stable while m_axis_tvalid=1 and m_axis_tready=0.
- Drop: sel=3, drop=1, en=1; s3 sends 5 beats with tlast on the 5th -> m_axis_tvalid stays 0; drop_count=5; state returns to IDLE; mux_busy falls.
- Mid-packet control change: while s0 is in PASS, set sel=1 after beat 2 of 6 -> all 6 beats still come from s0; the next packet comes from s1 after the 1-cycle IDLE bubble.
- en=0 after a packet ends -> FSM stays in IDLE; all tready=0; a pending s2 tvalid is never accepted.
- Assert aresetn=0 during beat 3 of a PASS packet -> m_axis_tvalid=0 asynchronously; all tready=0; after release the FSM is in IDLE and drop_count=0.
